// File: rtl/pwm_dt_pkg.sv
// Shared types and constants for the dead-time inserter.
package pwm_dt_pkg;

    localparam int unsigned DtWidthDefault = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLow   = 3'd1,
        StDtToH = 3'd2,
        StHigh  = 3'd3,
        StDtToL = 3'd4
    } ch_state_e;

endpackage

// File: rtl/pwm_dt_channel.sv
// One complementary gate-drive channel: state machine, dead-time counter and
// sticky short-pulse flag. Outputs are registered decodes of the current state.
module pwm_dt_channel
    import pwm_dt_pkg::*;
#(
    parameter int unsigned DT_WIDTH = DtWidthDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic [DT_WIDTH-1:0] i_deadtime,
    input  logic                i_pwm,
    input  logic                i_clear,
    output logic                o_pwm_h,
    output logic                o_pwm_l,
    output logic                o_dt_active,
    output logic                o_short_pulse
);

    ch_state_e           state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                h_q, h_d;
    logic                l_q, l_d;
    logic                dt_q, dt_d;
    logic                flag_q, flag_d;
    logic                set_flag;
    logic                dt_zero;
    logic                cnt_last;

    assign dt_zero  = (i_deadtime == '0);
    assign cnt_last = (cnt_q <= DT_WIDTH'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        set_flag = 1'b0;
        if (!i_enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dt_zero) begin
                        state_d = i_pwm ? StHigh : StLow;
                    end else begin
                        state_d = i_pwm ? StDtToH : StDtToL;
                        cnt_d   = i_deadtime;
                    end
                end
                StLow: begin
                    if (i_pwm) begin
                        state_d = dt_zero ? StHigh : StDtToH;
                        cnt_d   = i_deadtime;
                    end
                end
                StHigh: begin
                    if (!i_pwm) begin
                        state_d = dt_zero ? StLow : StDtToL;
                        cnt_d   = i_deadtime;
                    end
                end
                // Input went back before the dead time expired: return to the
                // side that is still safe and remember the absorbed pulse.
                StDtToH: begin
                    if (!i_pwm) begin
                        state_d  = StLow;
                        cnt_d    = '0;
                        set_flag = 1'b1;
                    end else if (cnt_last) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
                StDtToL: begin
                    if (i_pwm) begin
                        state_d  = StHigh;
                        cnt_d    = '0;
                        set_flag = 1'b1;
                    end else if (cnt_last) begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        h_d    = i_enable && (state_q == StHigh);
        l_d    = i_enable && (state_q == StLow);
        dt_d   = i_enable && ((state_q == StDtToH) || (state_q == StDtToL));
        flag_d = set_flag ? 1'b1 : (i_clear ? 1'b0 : flag_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            h_q     <= 1'b0;
            l_q     <= 1'b0;
            dt_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            l_q     <= l_d;
            dt_q    <= dt_d;
            flag_q  <= flag_d;
        end
    end

    assign o_pwm_h       = h_q;
    assign o_pwm_l       = l_q;
    assign o_dt_active   = dt_q;
    assign o_short_pulse = flag_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: registers the raw PWM once and drives one complementary
// channel per PWM bit.
module pwm_deadtime
    import pwm_dt_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DT_WIDTH     = DtWidthDefault
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic [DT_WIDTH-1:0]     i_deadtime,
    input  logic [NUM_CHANNELS-1:0] i_pwm,
    input  logic                    i_clear,
    output logic [NUM_CHANNELS-1:0] o_pwm_h,
    output logic [NUM_CHANNELS-1:0] o_pwm_l,
    output logic [NUM_CHANNELS-1:0] o_dt_active,
    output logic [NUM_CHANNELS-1:0] o_short_pulse
);

    logic [NUM_CHANNELS-1:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = i_pwm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        pwm_dt_channel #(
            .DT_WIDTH(DT_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_enable     (i_enable),
            .i_deadtime   (i_deadtime),
            .i_pwm        (pwm_q[g]),
            .i_clear      (i_clear),
            .o_pwm_h      (o_pwm_h[g]),
            .o_pwm_l      (o_pwm_l[g]),
            .o_dt_active  (o_dt_active[g]),
            .o_short_pulse(o_short_pulse[g])
        );
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime with a background non-overlap / gap monitor.
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_enable;
    logic [7:0] i_deadtime;
    logic [3:0] i_pwm;
    logic       i_clear;
    logic [3:0] o_pwm_h;
    logic [3:0] o_pwm_l;
    logic [3:0] o_dt_active;
    logic [3:0] o_short_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    logic       mon_en = 1'b0;
    logic       gap_en = 1'b0;
    int         gap_d  = 0;
    int         cyc    = 0;
    int         fall_h [4] = '{default: -1000};
    int         fall_l [4] = '{default: -1000};
    logic [3:0] h_prev;
    logic [3:0] l_prev;

    pwm_deadtime #(
        .NUM_CHANNELS(4),
        .DT_WIDTH    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_deadtime   (i_deadtime),
        .i_pwm        (i_pwm),
        .i_clear      (i_clear),
        .o_pwm_h      (o_pwm_h),
        .o_pwm_l      (o_pwm_l),
        .o_dt_active  (o_dt_active),
        .o_short_pulse(o_short_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] h, input logic [3:0] l,
                             input logic [3:0] dt);
        check({tag, "_h"}, 32'(o_pwm_h), 32'(h));
        check({tag, "_l"}, 32'(o_pwm_l), 32'(l));
        check({tag, "_dt"}, 32'(o_dt_active), 32'(dt));
    endtask

    // H and L must never overlap; every opposite-side rise waits at least D.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("no_overlap", 32'(o_pwm_h & o_pwm_l), 32'd0);
            for (int c = 0; c < 4; c++) begin
                if (h_prev[c] && !o_pwm_h[c]) fall_h[c] = cyc;
                if (l_prev[c] && !o_pwm_l[c]) fall_l[c] = cyc;
                if (gap_en && !h_prev[c] && o_pwm_h[c])
                    check("gap_to_h", ((cyc - fall_l[c]) >= gap_d) ? 32'd1 : 32'd0, 32'd1);
                if (gap_en && !l_prev[c] && o_pwm_l[c])
                    check("gap_to_l", ((cyc - fall_h[c]) >= gap_d) ? 32'd1 : 32'd0, 32'd1);
            end
        end
        h_prev = o_pwm_h;
        l_prev = o_pwm_l;
    end

    initial begin
        rst        = 1'b1;
        i_enable   = 1'b0;
        i_deadtime = 8'd0;
        i_pwm      = 4'b0000;
        i_clear    = 1'b0;
        tick();
        tick();
        check_out("reset", 4'h0, 4'h0, 4'h0);
        check("reset_sp", 32'(o_short_pulse), 32'd0);
        mon_en = 1'b1;

        // Enable with D=4, all inputs low: dead time before L comes on.
        rst        = 1'b0;
        i_enable   = 1'b1;
        i_deadtime = 8'd4;
        tick();
        check_out("en_first", 4'h0, 4'h0, 4'h0);
        tick();
        check_out("en_dt", 4'h0, 4'h0, 4'hf);
        repeat (6) tick();
        check_out("en_low", 4'h0, 4'hf, 4'h0);

        // Rising edge on ch0, D=4.
        i_pwm = 4'b0001;
        tick();
        check_out("rise_k", 4'h0, 4'hf, 4'h0);
        tick();
        check_out("rise_k1", 4'h0, 4'hf, 4'h0);
        tick();
        check_out("rise_k2", 4'h0, 4'he, 4'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("rise_dt", 4'h0, 4'he, 4'h1);
        end
        tick();
        check_out("rise_high", 4'h1, 4'he, 4'h0);

        // 3-cycle pulse on ch1 with D=6 is absorbed; clear coincides with the set.
        i_deadtime = 8'd6;
        i_pwm      = 4'b0011;
        repeat (3) tick();
        check_out("short_k2", 4'h1, 4'hc, 4'h2);
        i_pwm = 4'b0001;
        tick();
        check_out("short_k3", 4'h1, 4'hc, 4'h2);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("short_set_wins", 32'(o_short_pulse), 32'h2);
        tick();
        check_out("short_back", 4'h1, 4'he, 4'h0);
        repeat (3) tick();
        check("short_sticky", 32'(o_short_pulse), 32'h2);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("short_clear", 32'(o_short_pulse), 32'h0);

        // D changes 3 -> 10 during a count on ch2.
        i_deadtime = 8'd3;
        i_pwm      = 4'b0101;
        tick();
        tick();
        i_deadtime = 8'd10;
        tick();
        check_out("dchg_k2", 4'h1, 4'ha, 4'h4);
        tick();
        check_out("dchg_k3", 4'h1, 4'ha, 4'h4);
        tick();
        check_out("dchg_k4", 4'h1, 4'ha, 4'h4);
        tick();
        check_out("dchg_high", 4'h5, 4'ha, 4'h0);
        i_pwm = 4'b0001;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("dchg_dt10", 4'h1, 4'ha, 4'h4);
        end
        tick();
        check_out("dchg_low", 4'h1, 4'he, 4'h0);

        // D=0 square wave on ch3: complementary with no gap.
        i_deadtime = 8'd0;
        for (int i = 0; i < 32; i++) begin
            i_pwm[3] = i[2];
            tick();
            check("sq_compl", 32'(o_pwm_h[3] ^ o_pwm_l[3]), 32'd1);
            check("sq_no_dt", 32'(o_dt_active[3]), 32'd0);
        end
        i_pwm = 4'b0001;
        repeat (4) tick();
        check_out("sq_end", 4'h1, 4'he, 4'h0);

        // Disable while ch0 is HIGH, then re-enable with D=5.
        i_enable = 1'b0;
        tick();
        check_out("dis", 4'h0, 4'h0, 4'h0);
        i_deadtime = 8'd5;
        i_enable   = 1'b1;
        tick();
        check_out("reen_first", 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("reen_dt", 4'h0, 4'h0, 4'hf);
        end
        tick();
        check_out("reen_high", 4'h1, 4'he, 4'h0);

        // Reset while ch0 is HIGH, then restart with D=5.
        rst = 1'b1;
        tick();
        check_out("rst_mid", 4'h0, 4'h0, 4'h0);
        check("rst_sp", 32'(o_short_pulse), 32'd0);
        rst      = 1'b0;
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        tick();
        check_out("rst_reen_first", 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("rst_reen_dt", 4'h0, 4'h0, 4'hf);
        end
        tick();
        check_out("rst_reen_high", 4'h1, 4'he, 4'h0);
        check("rst_reen_sp", 32'(o_short_pulse), 32'd0);

        // Random toggling with a fixed random D.
        i_deadtime = 8'($urandom_range(0, 7));
        gap_d      = int'(i_deadtime);
        repeat (3) tick();
        gap_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 4) == 0) i_pwm[c] = ~i_pwm[c];
            end
            tick();
        end
        gap_en = 1'b0;
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of PWM channels; matches the PWM core channel count.
REQ-002 Parameter DT_WIDTH, default 8: width of the dead-time count in clk cycles.
REQ-003 Port clk, input, 1: the single clock; all logic is in this domain.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port i_enable, input, 1: global enable; low forces all channels to IDLE.
REQ-006 Port i_deadtime, input, DT_WIDTH: dead time D in cycles, shared by all channels.
REQ-007 Port i_pwm, input, NUM_CHANNELS: raw PWM from the core output pwm_out; asynchronous phase relative to this logic is not allowed (same clk).
REQ-008 Port i_clear, input, 1: one-cycle pulse that clears all o_short_pulse bits.
REQ-009 Port o_pwm_h, output, NUM_CHANNELS: high-side gate drive per channel.
REQ-010 Port o_pwm_l, output, NUM_CHANNELS: low-side gate drive per channel.
REQ-011 Port o_dt_active, output, NUM_CHANNELS: channel is in a dead-time state.
REQ-012 Port o_short_pulse, output, NUM_CHANNELS: sticky flag; an input pulse shorter than the dead time was absorbed.

Function
REQ-013 i_pwm is registered once (pwm_q) before use; all outputs are registered and decoded from state only (Moore).
REQ-014 Per-channel states: IDLE (H=0,L=0), LOW (L=1), DT_TO_H (H=0,L=0), HIGH (H=1), DT_TO_L (H=0,L=0).
REQ-015 o_pwm_h and o_pwm_l are never both 1 for a channel in any cycle, including across reset, enable and D changes.
REQ-016 IDLE -> DT_TO_H if pwm_q=1, else DT_TO_L, on the first cycle i_enable=1; dead time is always honoured after enable.
REQ-017 LOW with pwm_q=1 -> DT_TO_H, loading the counter with i_deadtime; HIGH with pwm_q=0 -> DT_TO_L likewise.
REQ-018 A DT state lasts exactly D cycles and then enters its target (HIGH or LOW); with D=0 the DT state is skipped and LOW->HIGH occurs in one transition.
REQ-019 Latency: an i_pwm edge sampled at edge k drops the active output after edge k+2; the opposite output rises D cycles later.
REQ-020 DT_TO_H with pwm_q=0 aborts to LOW and sets o_short_pulse; DT_TO_L with pwm_q=1 aborts to HIGH and sets the flag.
REQ-021 i_deadtime is sampled only on DT entry; a change mid-count affects the next transition only.
REQ-022 i_enable=0 forces IDLE on the next edge from any state and clears the counter; enable has priority over pwm_q.
REQ-023 o_dt_active=1 exactly in DT_TO_H and DT_TO_L.
REQ-024 i_clear clears o_short_pulse; when i_clear and a set event occur in the same cycle, the set wins.
REQ-025 Counter width is DT_WIDTH; the counter counts down to 1 and never wraps.

Reset
REQ-026 rst=1 sets every channel to IDLE, counters to 0, pwm_q to 0, and o_pwm_h, o_pwm_l, o_dt_active and o_short_pulse to 0 on the next edge, including mid-dead-time.
REQ-027 rst has priority over i_enable and i_clear.

Structure
REQ-028 Package pwm_dt_pkg holds the channel state enum typedef and the default DT_WIDTH constant.
REQ-029 Sub-module pwm_dt_channel implements one channel (FSM, counter, flag); the top level generates NUM_CHANNELS instances and the shared input register.

Verification
REQ-030 D=4, enable, i_pwm[0] 0->1 -> L falls 2 cycles after sampling, H rises 4 cycles later, o_dt_active high for exactly 4 cycles.
REQ-031 D=0, 50% square wave with period 8 -> H and L are complementary with no gap, and never both 1.
REQ-032 D=6, a 3-cycle high pulse on i_pwm[1] -> H stays 0, L returns, and o_short_pulse[1]=1 until i_clear.
REQ-033 D changes 3->10 during a DT_TO_H count -> the current gap is 3, and the next transition gap is 10.
REQ-034 i_enable dropped, or rst asserted, while in HIGH with i_pwm=1 -> all outputs are 0 the next cycle; on re-enable, a 5-cycle gap (D=5) precedes H.
REQ-035 Random i_pwm on 4 channels, random D, 10k cycles -> assertion holds that H&L is never true and every gap is at least the D sampled at entry.
